zone_finder_arbiter: RTL and testbench
======================================

Name: zone_finder_arbiter

Overview:
Shares one find_zone_adc_line instance between LINES ADC line sources. The block buffers each line's 32-sample frame and grants the finder to pending lines in round-robin order. For each grant it drives the frame and that line's per-line threshold into the finder, then captures the finder's result. Results are returned tagged with the line number, with a timeout and a flush window that protect against a stalled or late finder.

Parameters:
LINES, 4, number of requesting ADC lines (2..16); LW = clog2(LINES)
PORTS, 32, samples per frame; must match the finder
TIMEOUT, 96, cycles allowed in WAIT before a timeout is declared
THR_DEFAULT, 16'h0100, reset value of every per-line threshold

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
REQ_DATA  in  LINES*PORTS*21  per-line frames; line k occupies bits [k*PORTS*21 +: PORTS*21]; each sample is {idx[20:16], value[15:0]}
REQ_DAV  in  LINES  one-cycle strobe per line; the frame is valid on that cycle
REQ_PEND  out  LINES  frame buffered and not yet granted
REQ_OVF  out  LINES  sticky: a new frame arrived while the previous one was still pending
OVF_CLR  in  LINES  clears the matching REQ_OVF bits
CFG_WE  in  1  threshold write strobe
CFG_ADDR  in  LW  line whose threshold is written
CFG_THR  in  16  threshold value
F_IDATA  out  PORTS*21  frame driven to the finder IDATA input
F_IDAV  out  1  finder IDAV input
F_CMP_VALUE  out  16  finder MAX_CMP_VALUE input
F_MAX_VALUE  in  16  finder MAX_VALUE output
F_MAX_INDEX  in  5  finder MAX_VALUE_INDEX output
F_MAX_DAV  in  1  finder MAX_DAV output (level, may stay high across frames)
RES_VALUE  out  16  captured maximum value
RES_INDEX  out  5  captured centre index
RES_LINE  out  LW  line that produced the result
RES_TIMEOUT  out  1  result is a timeout; RES_VALUE and RES_INDEX are 0
RES_DAV  out  1  one-cycle result strobe
BUSY  out  1  state is not IDLE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs 0; F_CMP_VALUE = THR_DEFAULT.
  - Every threshold = THR_DEFAULT; all buffers 0; round-robin pointer = 0; state = IDLE; dav_prev = 0.
- Capture:
  - REQ_DAV[k] high: buffer[k] <= frame k and REQ_PEND[k] is set on the next edge.
  - If REQ_PEND[k] is already 1, the frame is overwritten and REQ_OVF[k] is set.
  - REQ_DAV[k] on the same cycle that line k is granted: the grant uses the old buffer, the new frame is latched, REQ_PEND[k] stays 1, and no overflow is flagged.
  - OVF_CLR loses to a simultaneous set.
- Config: a CFG_WE write takes effect for grants issued on the next cycle or later. The in-flight F_CMP_VALUE is not changed.
- Edge detect: dav_prev <= F_MAX_DAV every cycle. done = F_MAX_DAV & ~dav_prev. Only the rising edge counts; the level is ignored.
- FSM (one-hot):
  - IDLE: if any REQ_PEND, select the first pending line searching from pointer (wrapping past LINES-1) -> GRANT. Otherwise stay in IDLE.
  - GRANT (1 cycle):
    - Registers F_IDATA <= buffer[sel], F_CMP_VALUE <= thr[sel], F_IDAV <= 1, RES_LINE <= sel.
    - Clears REQ_PEND[sel]; pointer <= sel+1 mod LINES; timer <= 0; -> WAIT.
  - WAIT:
    - F_IDAV = 0. F_IDATA and F_CMP_VALUE are held stable. timer increments.
    - On done: capture RES_VALUE/RES_INDEX, RES_TIMEOUT <= 0 -> RESULT.
    - Else if timer == TIMEOUT-1: RES_VALUE/RES_INDEX <= 0, RES_TIMEOUT <= 1 -> RESULT.
    - done takes priority when it coincides with the timeout cycle.
  - RESULT (1 cycle): RES_DAV = 1. Next state is FLUSH if RES_TIMEOUT=1, else IDLE.
  - FLUSH: waits TIMEOUT cycles, discarding any done edges, -> IDLE.
  - Illegal state -> IDLE.
- Done edges arriving in IDLE or GRANT are discarded.
- Latency: from REQ_DAV to GRANT is at least 2 cycles when the finder is idle. RES_DAV comes 1 cycle after done.
- RES_* outputs other than RES_DAV hold their value until the next RESULT.

Test Plan:
- Single line 1, samples 5..9 = 0x0200, others 0x0010, thr 0x0100 -> one RES_DAV with RES_LINE=1, RES_VALUE=0x0200, RES_INDEX = finder centre; F_IDAV high exactly 1 cycle.
- REQ_DAV on lines 0,2,3 on the same cycle, pointer 0 -> results in order 0, 2, 3; the next lone request on line 0 is served after line 3 (wrap).
- Line 2 strobed twice before its grant -> one result from the second frame; REQ_OVF[2]=1 until OVF_CLR[2].
- Finder model never raises MAX_DAV -> RES_DAV after TIMEOUT+1 cycles with RES_TIMEOUT=1 and values 0; a late edge during FLUSH is ignored.
- F_MAX_DAV left high from the previous frame, next frame granted -> no result until the finder drops and re-raises MAX_DAV.
- Write thr[1]=0x0400 then grant line 1 -> F_CMP_VALUE=0x0400; rst_n pulsed low in WAIT -> all outputs 0 immediately, thresholds back to 0x0100.

Source files
------------

// File: rtl/zone_finder_arbiter.sv
// Shares one zone finder between LINES ADC line sources: buffers one frame per line,
// grants the finder round-robin and returns tagged results with timeout/flush protection.
module zone_finder_arbiter #(
   parameter int          LINES       = 4,
   parameter int          PORTS       = 32,
   parameter int          TIMEOUT     = 96,
   parameter logic [15:0] THR_DEFAULT = 16'h0100,
   localparam int         LW          = (LINES > 1) ? $clog2(LINES) : 1,
   localparam int         FW          = PORTS * 21
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LINES*FW-1:0]   REQ_DATA,
   input  logic [LINES-1:0]      REQ_DAV,
   output logic [LINES-1:0]      REQ_PEND,
   output logic [LINES-1:0]      REQ_OVF,
   input  logic [LINES-1:0]      OVF_CLR,
   input  logic                  CFG_WE,
   input  logic [LW-1:0]         CFG_ADDR,
   input  logic [15:0]           CFG_THR,
   output logic [FW-1:0]         F_IDATA,
   output logic                  F_IDAV,
   output logic [15:0]           F_CMP_VALUE,
   input  logic [15:0]           F_MAX_VALUE,
   input  logic [4:0]            F_MAX_INDEX,
   input  logic                  F_MAX_DAV,
   output logic [15:0]           RES_VALUE,
   output logic [4:0]            RES_INDEX,
   output logic [LW-1:0]         RES_LINE,
   output logic                  RES_TIMEOUT,
   output logic                  RES_DAV,
   output logic                  BUSY
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_GRANT  = 5'b00010,
      S_WAIT   = 5'b00100,
      S_RESULT = 5'b01000,
      S_FLUSH  = 5'b10000
   } state_t;

   state_t          state;
   logic [FW-1:0]   buffer [LINES];
   logic [15:0]     thr [LINES];
   logic [LW-1:0]   ptr;
   logic [LW-1:0]   sel;
   logic [TW-1:0]   timer;
   logic            dav_prev;
   logic            done;
   logic            granting;
   logic [LW-1:0]   pick;
   logic [LW-1:0]   cand;
   logic            pick_vld;

   assign done     = F_MAX_DAV & ~dav_prev;
   assign granting = (state == S_GRANT);
   assign BUSY     = (state != S_IDLE);

   // First pending line at or after the pointer, wrapping past the last line
   always_comb begin
      pick     = '0;
      cand     = '0;
      pick_vld = 1'b0;
      for (int i = 0; i < LINES; i++) begin
         cand = LW'((int'(ptr) + i) % LINES);
         if (!pick_vld && REQ_PEND[cand]) begin
            pick_vld = 1'b1;
            pick     = cand;
         end
      end
   end

   // A frame landing on its own grant cycle re-arms the line without counting as overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LINES; k++) buffer[k] <= '0;
         REQ_PEND <= '0;
         REQ_OVF  <= '0;
      end else begin
         for (int k = 0; k < LINES; k++) begin
            if (REQ_DAV[k]) begin
               buffer[k]   <= REQ_DATA[k*FW +: FW];
               REQ_PEND[k] <= 1'b1;
            end else if (granting && sel == LW'(k)) begin
               REQ_PEND[k] <= 1'b0;
            end
            if (REQ_DAV[k] && REQ_PEND[k] && !(granting && sel == LW'(k)))
               REQ_OVF[k] <= 1'b1;
            else if (OVF_CLR[k])
               REQ_OVF[k] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LINES; k++) thr[k] <= THR_DEFAULT;
      end else begin
         for (int k = 0; k < LINES; k++)
            if (CFG_WE && CFG_ADDR == LW'(k)) thr[k] <= CFG_THR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ptr         <= '0;
         sel         <= '0;
         timer       <= '0;
         dav_prev    <= 1'b0;
         F_IDATA     <= '0;
         F_IDAV      <= 1'b0;
         F_CMP_VALUE <= THR_DEFAULT;
         RES_VALUE   <= '0;
         RES_INDEX   <= '0;
         RES_LINE    <= '0;
         RES_TIMEOUT <= 1'b0;
         RES_DAV     <= 1'b0;
      end else begin
         dav_prev <= F_MAX_DAV;
         F_IDAV   <= 1'b0;
         RES_DAV  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  sel   <= pick;
                  state <= S_GRANT;
               end
            end
            S_GRANT: begin
               F_IDATA     <= buffer[sel];
               F_CMP_VALUE <= thr[sel];
               F_IDAV      <= 1'b1;
               RES_LINE    <= sel;
               ptr         <= (sel == LW'(LINES - 1)) ? '0 : sel + 1'b1;
               timer       <= '0;
               state       <= S_WAIT;
            end
            S_WAIT: begin
               timer <= timer + 1'b1;
               if (done) begin
                  RES_VALUE   <= F_MAX_VALUE;
                  RES_INDEX   <= F_MAX_INDEX;
                  RES_TIMEOUT <= 1'b0;
                  RES_DAV     <= 1'b1;
                  state       <= S_RESULT;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  RES_VALUE   <= '0;
                  RES_INDEX   <= '0;
                  RES_TIMEOUT <= 1'b1;
                  RES_DAV     <= 1'b1;
                  state       <= S_RESULT;
               end
            end
            S_RESULT: begin
               timer <= '0;
               state <= RES_TIMEOUT ? S_FLUSH : S_IDLE;
            end
            // A late finder answer after a timeout must not be taken for the next grant
            S_FLUSH: begin
               timer <= timer + 1'b1;
               if (timer == TW'(TIMEOUT - 1)) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_zone_finder_arbiter.sv
// Self-checking bench for zone_finder_arbiter: table of single-line frames plus directed
// sequences for round-robin, overflow, timeout/flush, sticky MAX_DAV, config and reset.
`timescale 1ns/1ps
module tb_zone_finder_arbiter;

   localparam int LINES   = 4;
   localparam int PORTS   = 32;
   localparam int TIMEOUT = 96;
   localparam int LW      = 2;
   localparam int FW      = PORTS * 21;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [LINES*FW-1:0] REQ_DATA;
   logic [LINES-1:0]    REQ_DAV;
   logic [LINES-1:0]    REQ_PEND;
   logic [LINES-1:0]    REQ_OVF;
   logic [LINES-1:0]    OVF_CLR;
   logic                CFG_WE;
   logic [LW-1:0]       CFG_ADDR;
   logic [15:0]         CFG_THR;
   logic [FW-1:0]       F_IDATA;
   logic                F_IDAV;
   logic [15:0]         F_CMP_VALUE;
   logic [15:0]         F_MAX_VALUE;
   logic [4:0]          F_MAX_INDEX;
   logic                F_MAX_DAV;
   logic [15:0]         RES_VALUE;
   logic [4:0]          RES_INDEX;
   logic [LW-1:0]       RES_LINE;
   logic                RES_TIMEOUT;
   logic                RES_DAV;
   logic                BUSY;

   zone_finder_arbiter #(.LINES(LINES), .PORTS(PORTS), .TIMEOUT(TIMEOUT), .THR_DEFAULT(16'h0100)) dut (
      .clk(clk), .rst_n(rst_n),
      .REQ_DATA(REQ_DATA), .REQ_DAV(REQ_DAV), .REQ_PEND(REQ_PEND), .REQ_OVF(REQ_OVF), .OVF_CLR(OVF_CLR),
      .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_THR(CFG_THR),
      .F_IDATA(F_IDATA), .F_IDAV(F_IDAV), .F_CMP_VALUE(F_CMP_VALUE),
      .F_MAX_VALUE(F_MAX_VALUE), .F_MAX_INDEX(F_MAX_INDEX), .F_MAX_DAV(F_MAX_DAV),
      .RES_VALUE(RES_VALUE), .RES_INDEX(RES_INDEX), .RES_LINE(RES_LINE),
      .RES_TIMEOUT(RES_TIMEOUT), .RES_DAV(RES_DAV), .BUSY(BUSY)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LW-1:0] line;
      logic [15:0]   value;
      logic [4:0]    index;
      logic          timeout;
      int            cyc;
   } res_t;

   typedef struct {
      int          line;
      int          hs;
      int          hl;
      logic [15:0] hv;
      logic [15:0] bv;
      logic [15:0] exp_val;
      logic [4:0]  exp_idx;
   } vec_t;

   typedef enum int {M_NORMAL, M_SILENT, M_STICKY} mode_t;

   int    checks;
   int    errors;
   int    cyc;
   int    idav_cycles;
   int    idav_long;
   logic  idav_prev;
   res_t  results[$];
   mode_t finder_mode;
   int    poke_req;
   int    poke_kind;

   always @(posedge clk) cyc <= cyc + 1;

   // Result and F_IDAV monitor, sampled on the falling edge
   always @(negedge clk) begin : monitor
      res_t r;
      if (RES_DAV === 1'b1) begin
         r.line    = RES_LINE;
         r.value   = RES_VALUE;
         r.index   = RES_INDEX;
         r.timeout = RES_TIMEOUT;
         r.cyc     = cyc;
         results.push_back(r);
      end
      if (F_IDAV === 1'b1) begin
         idav_cycles <= idav_cycles + 1;
         if (idav_prev === 1'b1) idav_long <= idav_long + 1;
      end
      idav_prev <= F_IDAV;
   end

   function automatic logic [FW-1:0] mk_frame(input int hs, input int hl, input logic [15:0] hv, input logic [15:0] bv);
      logic [FW-1:0] f;
      logic [4:0]    ix;
      f = '0;
      for (int p = 0; p < PORTS; p++) begin
         ix = 5'(p);
         f[p*21 +: 21] = {ix, (p >= hs && p < hs + hl) ? hv : bv};
      end
      return f;
   endfunction

   function automatic logic [LINES*FW-1:0] place(input logic [LINES*FW-1:0] d, input int line, input logic [FW-1:0] f);
      d[line*FW +: FW] = f;
      return d;
   endfunction

   // Reference finder: maximum value, index field of the centre of its first run
   function automatic void find_max(input logic [FW-1:0] fr, output logic [15:0] mv, output logic [4:0] mi);
      logic [15:0] best;
      logic [15:0] v;
      int s, e, c;
      best = '0; s = 0; e = 0;
      for (int p = 0; p < PORTS; p++) begin
         v = fr[p*21 +: 16];
         if (v > best) begin
            best = v; s = p; e = p;
         end else if (v == best && e == p - 1) begin
            e = p;
         end
      end
      c  = (s + e) / 2;
      mv = best;
      mi = fr[c*21 + 16 +: 5];
   endfunction

   initial begin : finder_model
      int          pd;
      logic [15:0] mv;
      logic [4:0]  mi;
      pd = 0; mv = '0; mi = '0;
      F_MAX_DAV = 1'b0; F_MAX_VALUE = '0; F_MAX_INDEX = '0;
      forever begin
         @(posedge clk); #1;
         if (pd != poke_req) begin
            pd = poke_req;
            if (poke_kind == 1) begin
               F_MAX_VALUE = 16'hFFFF; F_MAX_INDEX = 5'd31; F_MAX_DAV = 1'b1;
               @(posedge clk); #1;
               F_MAX_DAV = 1'b0;
            end else begin
               F_MAX_DAV = 1'b0;
               @(posedge clk); #1;
               F_MAX_VALUE = mv; F_MAX_INDEX = mi; F_MAX_DAV = 1'b1;
            end
         end else if (F_IDAV === 1'b1) begin
            find_max(F_IDATA, mv, mi);
            if (finder_mode == M_NORMAL) begin
               F_MAX_DAV = 1'b0;
               repeat (2) @(posedge clk); #1;
               F_MAX_VALUE = mv; F_MAX_INDEX = mi; F_MAX_DAV = 1'b1;
               repeat (2) @(posedge clk); #1;
               F_MAX_DAV = 1'b0;
            end else if (finder_mode == M_STICKY && F_MAX_DAV == 1'b0) begin
               repeat (2) @(posedge clk); #1;
               F_MAX_VALUE = mv; F_MAX_INDEX = mi; F_MAX_DAV = 1'b1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [LINES-1:0] mask, input logic [LINES*FW-1:0] data);
      REQ_DATA = data;
      REQ_DAV  = mask;
      @(posedge clk); #1;
      REQ_DAV  = '0;
   endtask

   task automatic wait_results(input string name, input int n, input int budget);
      for (int c = 0; c < budget && results.size() < n; c++) begin
         @(posedge clk); #1;
      end
      checkOutput({name, " result count"}, 32'(results.size()), 32'(n));
   endtask

   task automatic check_result(input string name, input int idx, input int line, input logic [15:0] val,
                               input logic [4:0] ix, input logic to);
      if (idx < results.size()) begin
         checkOutput({name, " line"}, 32'(results[idx].line), 32'(line));
         checkOutput({name, " value"}, 32'(results[idx].value), 32'(val));
         checkOutput({name, " index"}, 32'(results[idx].index), 32'(ix));
         checkOutput({name, " timeout"}, 32'(results[idx].timeout), 32'(to));
      end else begin
         checks++;
         errors++;
         $display("[TB] FAIL %s missing: got %0d results, required more than %0d", name, results.size(), idx);
      end
   endtask

   task automatic wait_fidav(input string name, output int t);
      for (int c = 0; c < 40 && F_IDAV !== 1'b1; c++) begin
         @(posedge clk); #1;
      end
      checkOutput({name, " F_IDAV seen"}, 32'(F_IDAV), 32'd1);
      t = cyc;
   endtask

   task automatic check_reset_outputs(input string name);
      checkOutput({name, " REQ_PEND"}, 32'(REQ_PEND), 32'd0);
      checkOutput({name, " REQ_OVF"}, 32'(REQ_OVF), 32'd0);
      checkOutput({name, " F_IDATA"}, 32'(|F_IDATA), 32'd0);
      checkOutput({name, " F_IDAV"}, 32'(F_IDAV), 32'd0);
      checkOutput({name, " F_CMP_VALUE"}, 32'(F_CMP_VALUE), 32'h0100);
      checkOutput({name, " RES_VALUE"}, 32'(RES_VALUE), 32'd0);
      checkOutput({name, " RES_INDEX"}, 32'(RES_INDEX), 32'd0);
      checkOutput({name, " RES_LINE"}, 32'(RES_LINE), 32'd0);
      checkOutput({name, " RES_TIMEOUT"}, 32'(RES_TIMEOUT), 32'd0);
      checkOutput({name, " RES_DAV"}, 32'(RES_DAV), 32'd0);
      checkOutput({name, " BUSY"}, 32'(BUSY), 32'd0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      vec_t                vecs[4];
      logic [LINES*FW-1:0] d;
      int                  base, ic0, t_idav;

      checks = 0; errors = 0; cyc = 0; idav_cycles = 0; idav_long = 0; idav_prev = 1'b0;
      finder_mode = M_NORMAL; poke_req = 0; poke_kind = 0;
      rst_n = 1'b0; REQ_DATA = '0; REQ_DAV = '0; OVF_CLR = '0;
      CFG_WE = 1'b0; CFG_ADDR = '0; CFG_THR = '0;

      vecs[0] = '{1,  5, 5, 16'h0200, 16'h0010, 16'h0200, 5'd7};
      vecs[1] = '{0, 29, 3, 16'h1234, 16'h0100, 16'h1234, 5'd30};
      vecs[2] = '{2, 12, 3, 16'h0050, 16'h0010, 16'h0050, 5'd13};
      vecs[3] = '{3,  0, 1, 16'h7FFF, 16'h0001, 16'h7FFF, 5'd0};

      repeat (3) @(posedge clk); #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single-line frames; the last one is line 3 so the pointer ends back at 0
      for (int v = 0; v < 4; v++) begin
         base = results.size();
         ic0  = idav_cycles;
         applyStimulus(4'(1 << vecs[v].line),
                       place('0, vecs[v].line, mk_frame(vecs[v].hs, vecs[v].hl, vecs[v].hv, vecs[v].bv)));
         wait_results($sformatf("vec%0d", v), base + 1, 60);
         repeat (3) @(posedge clk); #1;
         check_result($sformatf("vec%0d", v), base, vecs[v].line, vecs[v].exp_val, vecs[v].exp_idx, 1'b0);
         checkOutput($sformatf("vec%0d held RES_VALUE", v), 32'(RES_VALUE), 32'(vecs[v].exp_val));
         checkOutput($sformatf("vec%0d F_IDAV cycles", v), 32'(idav_cycles - ic0), 32'd1);
         checkOutput($sformatf("vec%0d REQ_PEND", v), 32'(REQ_PEND), 32'd0);
         checkOutput($sformatf("vec%0d F_CMP_VALUE", v), 32'(F_CMP_VALUE), 32'h0100);
      end

      // Round robin: 0,2,3 together, then 0 again while 2 and 3 still wait
      base = results.size();
      d = place('0, 0, mk_frame(3, 1, 16'h0A00, 16'h0010));
      d = place(d, 2, mk_frame(20, 3, 16'h0B00, 16'h0010));
      d = place(d, 3, mk_frame(31, 1, 16'h0C00, 16'h0010));
      applyStimulus(4'b1101, d);
      wait_results("rr first", base + 1, 60);
      applyStimulus(4'b0001, place('0, 0, mk_frame(16, 1, 16'h0D00, 16'h0010)));
      wait_results("rr all", base + 4, 200);
      check_result("rr0", base,     0, 16'h0A00, 5'd3,  1'b0);
      check_result("rr1", base + 1, 2, 16'h0B00, 5'd21, 1'b0);
      check_result("rr2", base + 2, 3, 16'h0C00, 5'd31, 1'b0);
      check_result("rr3", base + 3, 0, 16'h0D00, 5'd16, 1'b0);

      // Overflow: line 2 strobed on two consecutive cycles before its grant
      base = results.size();
      applyStimulus(4'b0100, place('0, 2, mk_frame(8, 1, 16'h0111, 16'h0010)));
      applyStimulus(4'b0100, place('0, 2, mk_frame(9, 3, 16'h0222, 16'h0010)));
      wait_results("ovf2", base + 1, 60);
      repeat (20) @(posedge clk); #1;
      checkOutput("ovf2 single result", 32'(results.size()), 32'(base + 1));
      check_result("ovf2", base, 2, 16'h0222, 5'd10, 1'b0);
      checkOutput("ovf2 REQ_OVF set", 32'(REQ_OVF), 32'h4);
      OVF_CLR = 4'b0100;
      @(posedge clk); #1;
      OVF_CLR = '0;
      checkOutput("ovf2 REQ_OVF cleared", 32'(REQ_OVF), 32'h0);

      // Overflow set wins against a clear on the same cycle
      base = results.size();
      applyStimulus(4'b0010, place('0, 1, mk_frame(2, 1, 16'h0333, 16'h0010)));
      OVF_CLR = 4'b0010;
      applyStimulus(4'b0010, place('0, 1, mk_frame(4, 1, 16'h0344, 16'h0010)));
      OVF_CLR = '0;
      checkOutput("ovf1 set beats clear", 32'(REQ_OVF), 32'h2);
      wait_results("ovf1", base + 1, 60);
      check_result("ovf1", base, 1, 16'h0344, 5'd4, 1'b0);
      OVF_CLR = 4'b0010;
      @(posedge clk); #1;
      OVF_CLR = '0;
      checkOutput("ovf1 REQ_OVF cleared", 32'(REQ_OVF), 32'h0);

      // Timeout: finder silent, then a late edge during the flush window
      finder_mode = M_SILENT;
      base = results.size();
      applyStimulus(4'b0010, place('0, 1, mk_frame(5, 5, 16'h0200, 16'h0010)));
      wait_fidav("timeout", t_idav);
      wait_results("timeout", base + 1, TIMEOUT + 20);
      check_result("timeout", base, 1, 16'h0000, 5'd0, 1'b1);
      if (base < results.size())
         checkOutput("timeout latency", 32'(results[base].cyc - t_idav), 32'(TIMEOUT));
      poke_kind = 1;
      poke_req++;
      repeat (10) @(posedge clk); #1;
      checkOutput("flush BUSY", 32'(BUSY), 32'd1);
      repeat (TIMEOUT + 10) @(posedge clk); #1;
      checkOutput("flush ignores late edge", 32'(results.size()), 32'(base + 1));
      checkOutput("flush ends BUSY", 32'(BUSY), 32'd0);
      checkOutput("flush RES_TIMEOUT held", 32'(RES_TIMEOUT), 32'd1);

      // MAX_DAV left high: the next grant waits for a fresh rising edge
      finder_mode = M_STICKY;
      base = results.size();
      applyStimulus(4'b0001, place('0, 0, mk_frame(6, 1, 16'h0300, 16'h0010)));
      wait_results("sticky first", base + 1, 60);
      check_result("sticky first", base, 0, 16'h0300, 5'd6, 1'b0);
      applyStimulus(4'b1000, place('0, 3, mk_frame(24, 5, 16'h0444, 16'h0010)));
      repeat (30) @(posedge clk); #1;
      checkOutput("sticky level ignored", 32'(results.size()), 32'(base + 1));
      checkOutput("sticky BUSY", 32'(BUSY), 32'd1);
      poke_kind = 2;
      poke_req++;
      wait_results("sticky second", base + 2, 20);
      check_result("sticky second", base + 1, 3, 16'h0444, 5'd26, 1'b0);

      // Threshold write, in-flight hold, then asynchronous reset in WAIT
      finder_mode = M_SILENT;
      repeat (2) @(posedge clk); #1;
      CFG_WE = 1'b1; CFG_ADDR = 2'd1; CFG_THR = 16'h0400;
      @(posedge clk); #1;
      CFG_WE = 1'b0;
      applyStimulus(4'b0010, place('0, 1, mk_frame(5, 5, 16'h0200, 16'h0010)));
      wait_fidav("cfg", t_idav);
      checkOutput("cfg F_CMP_VALUE", 32'(F_CMP_VALUE), 32'h0400);
      CFG_WE = 1'b1; CFG_ADDR = 2'd1; CFG_THR = 16'h0999;
      @(posedge clk); #1;
      CFG_WE = 1'b0;
      applyStimulus(4'b0100, place('0, 2, mk_frame(1, 1, 16'h0555, 16'h0010)));
      repeat (3) @(posedge clk); #1;
      checkOutput("cfg in-flight held", 32'(F_CMP_VALUE), 32'h0400);
      checkOutput("cfg RES_LINE", 32'(RES_LINE), 32'd1);
      checkOutput("cfg pending before reset", 32'(REQ_PEND), 32'h4);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      finder_mode = M_NORMAL;
      base = results.size();
      applyStimulus(4'b0010, place('0, 1, mk_frame(5, 5, 16'h0200, 16'h0010)));
      wait_fidav("post-reset", t_idav);
      checkOutput("post-reset threshold", 32'(F_CMP_VALUE), 32'h0100);
      wait_results("post-reset", base + 1, 60);
      check_result("post-reset", base, 1, 16'h0200, 5'd7, 1'b0);

      checkOutput("F_IDAV never wider than 1 cycle", 32'(idav_long), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
